cruce_scheduler: RTL

Moore-style scheduler for a two-street intersection. It shares the crossing between requesters A and B by sequencing green, yellow and all-red phases. Per-phase dwell counters enforce a minimum green time, a maximum green time under contention, and a fixed yellow time. It drives the light datapath and exposes its present and next state for bench monitoring.

---
 rtl/cruce_scheduler.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/cruce_scheduler.sv
// -----------------------------------------------------------------------------
// cruce_scheduler
// Moore-style scheduler for a two-street intersection. Streets A and B share
// the crossing through green -> yellow -> all-red phases. A per-state dwell
// counter enforces a minimum green (when the opposite street waits and the own
// street is idle), a maximum green (when both streets request), and a fixed
// yellow time. The all-red phase always lasts exactly one cycle.
//
// Ports:
//   CLK    in   1   system clock, rising-edge active
//   reset  in   1   asynchronous active-low reset
//   A      in   1   car waiting on street A (level)
//   B      in   1   car waiting on street B (level)
//   LA     out  2   street A light: 00 green, 01 yellow, 10 red
//   LB     out  2   street B light, same encoding
//   SP     out  3   present state
//   SF     out  3   next state (combinational from SP, cnt, A, B)
//   cnt    out  CW  cycles already spent in the present state (saturating)
// -----------------------------------------------------------------------------
module cruce_scheduler #(
    parameter int GREEN_MIN = 5,
    parameter int GREEN_MAX = 15,
    parameter int YELLOW    = 2,
    parameter int CW        = 4
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          A,
    input  logic          B,
    output logic [1:0]    LA,
    output logic [1:0]    LB,
    output logic [2:0]    SP,
    output logic [2:0]    SF,
    output logic [CW-1:0] cnt
);

    typedef enum logic [2:0] {
        A_GREEN  = 3'b000,
        A_YELLOW = 3'b001,
        RED_AB   = 3'b010,
        B_GREEN  = 3'b011,
        B_YELLOW = 3'b100,
        RED_BA   = 3'b101
    } state_t;

    localparam logic [1:0] L_GREEN  = 2'b00;
    localparam logic [1:0] L_YELLOW = 2'b01;
    localparam logic [1:0] L_RED    = 2'b10;

    // Thresholds expressed as "cnt value on the last cycle of the dwell".
    localparam logic [CW-1:0] GMIN_LAST = CW'(GREEN_MIN - 1);
    localparam logic [CW-1:0] GMAX_LAST = CW'(GREEN_MAX - 1);
    localparam logic [CW-1:0] YEL_LAST  = CW'(YELLOW - 1);
    localparam logic [CW-1:0] CNT_TOP   = {CW{1'b1}};

    logic a_yield_s;
    logic b_yield_s;
    logic yel_done_s;

    // Saturating increment: an idle green rests forever without wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (v == CNT_TOP) begin
            sat_inc = CNT_TOP;
        end else begin
            sat_inc = v + {{(CW-1){1'b0}}, 1'b1};
        end
    endfunction

    // Yield conditions for each green and the yellow completion flag.
    always_comb begin
        a_yield_s  = B && ((!A && (cnt >= GMIN_LAST)) || (cnt >= GMAX_LAST));
        b_yield_s  = A && ((!B && (cnt >= GMIN_LAST)) || (cnt >= GMAX_LAST));
        yel_done_s = (cnt == YEL_LAST);
    end

    // Next-state decode; illegal codes fall into RED_BA to recover via A_GREEN.
    always_comb begin
        SF = SP;
        case (SP)
            A_GREEN: begin
                if (a_yield_s) begin
                    SF = A_YELLOW;
                end else begin
                    SF = A_GREEN;
                end
            end
            A_YELLOW: begin
                if (yel_done_s) begin
                    SF = RED_AB;
                end else begin
                    SF = A_YELLOW;
                end
            end
            RED_AB:  SF = B_GREEN;
            B_GREEN: begin
                if (b_yield_s) begin
                    SF = B_YELLOW;
                end else begin
                    SF = B_GREEN;
                end
            end
            B_YELLOW: begin
                if (yel_done_s) begin
                    SF = RED_BA;
                end else begin
                    SF = B_YELLOW;
                end
            end
            RED_BA:  SF = A_GREEN;
            default: SF = RED_BA;
        endcase
    end

    // Moore light decode from the present state only; anything unknown is red.
    always_comb begin
        LA = L_RED;
        LB = L_RED;
        case (SP)
            A_GREEN:  begin LA = L_GREEN;  LB = L_RED;    end
            A_YELLOW: begin LA = L_YELLOW; LB = L_RED;    end
            B_GREEN:  begin LA = L_RED;    LB = L_GREEN;  end
            B_YELLOW: begin LA = L_RED;    LB = L_YELLOW; end
            default:  begin LA = L_RED;    LB = L_RED;    end
        endcase
    end

    // State register and dwell counter; counter restarts on every state change.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            SP  <= A_GREEN;
            cnt <= {CW{1'b0}};
        end else begin
            SP <= SF;
            if (SF != SP) begin
                cnt <= {CW{1'b0}};
            end else begin
                cnt <= sat_inc(cnt);
            end
        end
    end

endmodule
